sample_scheduler: RTL and testbench
===================================

# sample_scheduler

Periodic acquisition controller for the voltage/current sampler. It raises the sampler's start request at a programmable cycle interval and runs a bounded burst or continuous acquisition. Each completed result is captured into a small show-ahead FIFO for the downstream consumer. It sits between the sampler and the host/register logic, and flags overrun, late-trigger and stalled-sampler conditions.

## Interface
- PERIOD_W, 16, width of trigger period in clk cycles
- DATA_W, 24, sampler result width ({voltage[11:0], current[11:0]})
- FIFO_DEPTH, 4, result FIFO entries; power of 2, ≥2
- TIMEOUT, 4096, max cycles allowed in WAIT_BUSY or WAIT_DONE before abort
- clk  in  1  single system clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = run acquisition, 0 = stop after current conversion
- period  in  PERIOD_W  trigger interval in cycles; 0 treated as 1; sampled at each TRIGGER
- burst_len  in  8  samples per run; 0 = continuous; sampled on IDLE exit
- samp_start  out  1  start request to sampler (registered)
- samp_busy  in  1  sampler busy
- samp_new_data  in  1  sampler result valid (level)
- samp_data  in  DATA_W  sampler result
- rd_en  in  1  pop FIFO head; ignored when empty
- rd_data  out  DATA_W  FIFO head (show-ahead), valid when !fifo_empty
- fifo_empty, fifo_full  out  1  FIFO status
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- active  out  1  1 in every state except IDLE
- done  out  1  one-cycle pulse when a burst completes normally
- overrun, late, timeout_err  out  1  sticky error flags
- clr_err  in  1  synchronous clear of all sticky flags

## Operation
- States: IDLE, TRIGGER, WAIT_BUSY, WAIT_DONE, WAIT_TICK.
- IDLE: when enable=1, latch burst_len, clear sample counter, go to TRIGGER. There is no wait for the first tick.
- TRIGGER:
  - Set samp_start=1.
  - Load tick counter with max(period,1)-1.
  - Go to WAIT_BUSY.
- WAIT_BUSY: hold samp_start=1 until samp_busy=1. Then clear samp_start and go to WAIT_DONE.
- WAIT_DONE: when samp_busy=0 and samp_new_data=1:
  - Push samp_data and increment sample counter.
  - If burst_len≠0 and count==burst_len, pulse done and go to IDLE.
  - Otherwise, if enable=0, go to IDLE without done.
  - Otherwise go to WAIT_TICK.
- WAIT_TICK:
  - enable=0 goes to IDLE immediately.
  - Tick counter ==0 goes to TRIGGER.
- Tick counter decrements every cycle in all non-IDLE states and saturates at 0.
- Late trigger: if the counter reaches 0 while in WAIT_BUSY or WAIT_DONE, set late. TRIGGER follows immediately after WAIT_TICK is entered.
- Timeout:
  - A watchdog counter resets on entry to WAIT_BUSY and on entry to WAIT_DONE.
  - Reaching TIMEOUT sets timeout_err, clears samp_start and goes to IDLE.
  - No push and no done on timeout.
- Stop:
  - enable falling during TRIGGER/WAIT_BUSY/WAIT_DONE: the in-flight conversion completes and is pushed, then IDLE.
  - enable falling during WAIT_TICK: IDLE immediately.
- FIFO:
  - Circular buffer, show-ahead read.
  - Push when full: data dropped, overrun set, contents unchanged.
  - Push and rd_en in the same cycle when full: pop and push both succeed, no overrun, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_err has priority over a same-cycle flag set. Flags read 0 the next cycle.
- Sample counter is 8-bit. In continuous mode it wraps without effect.

## Timing
- Reset (async assert, sync deassert upstream) values:
  - samp_start=0, active=0, done=0.
  - overrun=late=timeout_err=0.
  - fifo_empty=1, fifo_full=0, fifo_count=0, rd_data=0.
  - State IDLE.
- Reset mid-run aborts immediately. FIFO contents are discarded.
- enable=1 in IDLE at edge N: active=1 at N+1, samp_start=1 at N+2 (after TRIGGER).
- Consecutive samp_start rising edges are spaced exactly max(period,1) cycles when conversion + handshake completes before the tick expires. Otherwise they are spaced conversion-limited and late is set.
- Capture: edge where samp_busy=0 & samp_new_data=1 in WAIT_DONE. fifo_count and rd_data update at the next edge.
- rd_en pops at the edge. The new head appears on rd_data the same cycle as the updated fifo_count.
- done is high for exactly one cycle, coincident with the IDLE entry edge.

## Test plan
- Burst: period=100, burst_len=3, sampler model busy 1 cycle after start for 40 cycles, data 0xA5A123/0xA5A124/0xA5A125 -> samp_start edges at T, T+100, T+200; three pushes in order; done pulses once; active returns to 0; no flags.
- Overrun: FIFO_DEPTH=4, burst_len=6, no reads -> fifo_full after 4th; 5th and 6th dropped; overrun=1; rd_data still 1st result. Then 4 reads return samples 1–4 and the FIFO is empty.
- Late: period=10, conversion 40 cycles, burst_len=2 -> late=1; second samp_start is asserted the cycle after WAIT_TICK entry; clr_err clears late.
- Timeout: TIMEOUT=64, sampler never asserts busy -> samp_start is held for 64 cycles then drops; timeout_err=1; IDLE; no push, no done.
- Stop: burst_len=0, period=200, drop enable mid-conversion -> that sample is pushed, then IDLE, no done. Drop enable in WAIT_TICK -> IDLE the next cycle with no further samp_start.
- Full push+pop: FIFO full, rd_en coincident with capture -> fifo_count stays 4, overrun=0, new result at tail. Assert rst_n=0 mid-WAIT_DONE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sample_scheduler.sv
// Periodic acquisition controller: triggers the sampler every `period` cycles for a
// bounded or continuous run, captures results into a show-ahead FIFO, and flags errors.
module sample_scheduler #(
    parameter int PERIOD_W   = 16,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [PERIOD_W-1:0]         period,
    input  logic [7:0]                  burst_len,
    output logic                        samp_start,
    input  logic                        samp_busy,
    input  logic                        samp_new_data,
    input  logic [DATA_W-1:0]           samp_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        fifo_empty,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        active,
    output logic                        done,
    output logic                        overrun,
    output logic                        late,
    output logic                        timeout_err,
    input  logic                        clr_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_BUSY, WAIT_DONE, WAIT_TICK} state_t;

    state_t              state;
    logic [PERIOD_W-1:0] tick;
    logic [WD_W-1:0]     wd;
    logic [7:0]          burst_lat;
    logic [7:0]          samp_cnt;
    logic [7:0]          cnt_next;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                capture;
    logic                pop;
    logic                push_ok;
    logic                tick_last;
    logic                in_wait;
    logic                wd_expire;

    // NOTE: every signal driven here is fully assigned on every pass, so no latch is inferred.
    always_comb begin
        capture   = (state == WAIT_DONE) && !samp_busy && samp_new_data;
        pop       = rd_en && !fifo_empty;
        push_ok   = capture && (!fifo_full || pop);
        cnt_next  = samp_cnt + 8'd1;
        tick_last = (tick <= PERIOD_W'(1));
        in_wait   = (state == WAIT_BUSY) || (state == WAIT_DONE);
        // A handshake arriving on the expiry edge wins over the abort.
        wd_expire = (wd == WD_W'(TIMEOUT - 1)) &&
                    (((state == WAIT_BUSY) && !samp_busy) ||
                     ((state == WAIT_DONE) && !capture));
    end

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign rd_data    = mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick       <= '0;
            wd         <= '0;
            burst_lat  <= '0;
            samp_cnt   <= '0;
            samp_start <= 1'b0;
            active     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && tick != '0) tick <= tick - 1'b1;
            if (in_wait) wd <= wd + 1'b1;
            case (state)
                IDLE: begin
                    if (enable) begin
                        burst_lat <= burst_len;
                        samp_cnt  <= '0;
                        active    <= 1'b1;
                        state     <= TRIGGER;
                    end
                end
                TRIGGER: begin
                    samp_start <= 1'b1;
                    tick       <= (period == '0) ? '0 : period - 1'b1;
                    wd         <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (samp_busy) begin
                        samp_start <= 1'b0;
                        wd         <= '0;
                        state      <= WAIT_DONE;
                    end else if (wd_expire) begin
                        samp_start <= 1'b0;
                        active     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (capture) begin
                        samp_cnt <= cnt_next;
                        if (burst_lat != '0 && cnt_next == burst_lat) begin
                            done   <= 1'b1;
                            active <= 1'b0;
                            state  <= IDLE;
                        end else if (!enable) begin
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end else if (wd_expire) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end else if (tick_last) begin
                        state <= TRIGGER;
                    end
                end
                default: begin
                    samp_start <= 1'b0;
                    active     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a same-cycle clear beats a set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            late        <= 1'b0;
            timeout_err <= 1'b0;
        end else if (clr_err) begin
            overrun     <= 1'b0;
            late        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (capture && !push_ok) overrun <= 1'b1;
            if (in_wait && tick_last) late <= 1'b1;
            if (wd_expire) timeout_err <= 1'b1;
        end
    end

    // NOTE: the small FIFO array is reset so rd_data reads 0 and stale results vanish on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= samp_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_scheduler.sv
// Directed self-checking bench for sample_scheduler with a behavioural sampler model.
module tb_sample_scheduler;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] period;
    logic [7:0]  burst_len;
    logic        samp_start;
    logic        samp_busy;
    logic        samp_new_data;
    logic [23:0] samp_data;
    logic        rd_en;
    logic [23:0] rd_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        active;
    logic        done;
    logic        overrun;
    logic        late;
    logic        timeout_err;
    logic        clr_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          start_q[$];
    logic        start_prev = 1'b0;
    int          conv_cycles = 40;
    int          conv_left = 0;
    logic        respond = 1'b1;
    logic [23:0] next_data = '0;

    sample_scheduler #(
        .PERIOD_W(16), .DATA_W(24), .FIFO_DEPTH(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .burst_len(burst_len),
        .samp_start(samp_start), .samp_busy(samp_busy), .samp_new_data(samp_new_data),
        .samp_data(samp_data), .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .active(active), .done(done),
        .overrun(overrun), .late(late), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sampler: goes busy the cycle after it sees start, stays busy conv_cycles, then presents data.
    initial begin
        samp_busy = 1'b0;
        samp_new_data = 1'b0;
        samp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                samp_busy = 1'b0;
                samp_new_data = 1'b0;
                conv_left = 0;
            end else if (conv_left != 0) begin
                conv_left--;
                if (conv_left == 0) begin
                    samp_busy = 1'b0;
                    samp_new_data = 1'b1;
                    samp_data = next_data;
                    next_data = next_data + 24'd1;
                end
            end else if (samp_start && !samp_busy && respond) begin
                samp_busy = 1'b1;
                samp_new_data = 1'b0;
                conv_left = conv_cycles;
            end
        end
    end

    // Monitor: cycle count, samp_start rising-edge times and done pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (samp_start && !start_prev) start_q.push_back(cyc);
            start_prev = samp_start;
            if (done) done_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (start_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(start_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (active && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, active, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [23:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic new_test(input logic [15:0] p, input logic [7:0] bl, input int conv,
                            input logic [23:0] base);
        period = p;
        burst_len = bl;
        conv_cycles = conv;
        next_data = base;
        start_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int k;
        int hi;
        rst_n = 1'b0;
        enable = 1'b0;
        period = '0;
        burst_len = '0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", samp_start, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_flags", {overrun, late, timeout_err}, 3'b000);
        check("rst_fifo", {fifo_empty, fifo_full, fifo_count}, 5'b10000);
        check("rst_rd_data", rd_data, 24'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Burst of 3, period 100, conversions 40 cycles.
        new_test(16'd100, 8'd3, 40, 24'hA5A123);
        enable = 1'b1;
        @(negedge clk);
        check("burst_active_n1", active, 1'b1);
        check("burst_start_n1", samp_start, 1'b0);
        @(negedge clk);
        check("burst_start_n2", samp_start, 1'b1);
        wait_starts(3, 400, "burst_three_starts");
        enable = 1'b0;
        wait_done(100, "burst_done");
        check("burst_idle_at_done", active, 1'b0);
        check("burst_count", fifo_count, 3'd3);
        @(negedge clk);
        check("burst_done_width", done, 1'b0);
        if (start_q.size() >= 3) begin
            check("burst_spacing1", start_q[1] - start_q[0], 100);
            check("burst_spacing2", start_q[2] - start_q[0], 200);
        end
        repeat (3) @(negedge clk);
        check("burst_done_once", done_cnt, 1);
        check("burst_flags", {overrun, late, timeout_err}, 3'b000);
        pop_expect("burst_data0", 24'hA5A123);
        pop_expect("burst_data1", 24'hA5A124);
        pop_expect("burst_data2", 24'hA5A125);
        check("burst_empty", fifo_empty, 1'b1);

        // Overrun: 6 samples, no reads, depth 4.
        new_test(16'd10, 8'd6, 5, 24'h100001);
        enable = 1'b1;
        wait_starts(6, 200, "ovr_six_starts");
        enable = 1'b0;
        wait_done(50, "ovr_done");
        @(negedge clk);
        check("ovr_full", fifo_full, 1'b1);
        check("ovr_count", fifo_count, 3'd4);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_no_late", late, 1'b0);
        for (int i = 0; i < 4; i++) pop_expect("ovr_data", 24'h100001 + 24'(i));
        check("ovr_empty", fifo_empty, 1'b1);
        clear_errors();
        check("ovr_cleared", overrun, 1'b0);

        // Late: period 10 but conversion 40.
        new_test(16'd10, 8'd2, 40, 24'h200001);
        enable = 1'b1;
        wait_starts(2, 200, "late_two_starts");
        enable = 1'b0;
        wait_done(100, "late_done");
        @(negedge clk);
        check("late_flag", late, 1'b1);
        // Capture lands 41 cycles after start; WAIT_TICK then TRIGGER then start: 43.
        if (start_q.size() >= 2) check("late_spacing", start_q[1] - start_q[0], 43);
        check("late_no_timeout", timeout_err, 1'b0);
        pop_expect("late_data0", 24'h200001);
        pop_expect("late_data1", 24'h200002);
        clear_errors();
        check("late_cleared", late, 1'b0);

        // Timeout: sampler never answers.
        new_test(16'd100, 8'd1, 40, 24'h0);
        respond = 1'b0;
        enable = 1'b1;
        wait_starts(1, 20, "to_start");
        enable = 1'b0;
        hi = 0;
        while (samp_start && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        check("to_start_width", hi, 64);
        check("to_flag", timeout_err, 1'b1);
        check("to_idle", active, 1'b0);
        check("to_no_push", fifo_count, 3'd0);
        repeat (3) @(negedge clk);
        check("to_no_done", done_cnt, 0);
        respond = 1'b1;
        clear_errors();
        check("to_cleared", timeout_err, 1'b0);

        // Stop: continuous mode, enable drops mid-conversion then during WAIT_TICK.
        new_test(16'd200, 8'd0, 40, 24'h300001);
        enable = 1'b1;
        wait_starts(1, 20, "stop_start");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle(100, "stop_idle");
        check("stop_pushed", fifo_count, 3'd1);
        check("stop_data", rd_data, 24'h300001);
        repeat (2) @(negedge clk);
        check("stop_no_done", done_cnt, 0);
        start_q.delete();
        enable = 1'b1;
        wait_starts(1, 20, "stop2_start");
        k = 0;
        while (fifo_count != 3'd2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stop2_captured", fifo_count, 3'd2);
        enable = 1'b0;
        @(negedge clk);
        check("stop2_idle_next", active, 1'b0);
        repeat (250) @(negedge clk);
        check("stop2_no_restart", start_q.size(), 1);
        pop_expect("stop2_data0", 24'h300001);
        pop_expect("stop2_data1", 24'h300002);

        // Full FIFO with a pop coincident with the capture.
        new_test(16'd10, 8'd5, 5, 24'h400001);
        enable = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (start_q.size() >= 5) begin
                enable = 1'b0;
                if (samp_new_data && !samp_busy) break;
            end
        end
        check("fpp_full_before", fifo_count, 3'd4);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("fpp_count", fifo_count, 3'd4);
        check("fpp_no_overrun", overrun, 1'b0);
        check("fpp_done", done, 1'b1);
        for (int i = 0; i < 4; i++) pop_expect("fpp_data", 24'h400002 + 24'(i));
        check("fpp_empty", fifo_empty, 1'b1);

        // Reset in the middle of WAIT_DONE.
        new_test(16'd50, 8'd0, 5, 24'h500001);
        enable = 1'b1;
        wait_starts(2, 200, "rstmid_starts");
        repeat (2) @(negedge clk);
        check("rstmid_active_pre", active, 1'b1);
        check("rstmid_count_pre", fifo_count, 3'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_active", active, 1'b0);
        check("rstmid_start", samp_start, 1'b0);
        check("rstmid_fifo", {fifo_empty, fifo_full, fifo_count}, 5'b10000);
        check("rstmid_rd_data", rd_data, 24'h0);
        check("rstmid_flags", {overrun, late, timeout_err, done}, 4'b0000);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
